// File: rtl/fpmul_arb_pkg.sv
// fpmul_arb_pkg: shared defaults, FSM encoding and counter width for the
// two-requester FPmul arbiter.
package fpmul_arb_pkg;

  localparam int unsigned W_DEF     = 32;  // IEEE-754 single
  localparam int unsigned LAT_DEF   = 4;   // FPmul MUL_VIN->MUL_VOUT latency
  localparam int unsigned GNT_CNT_W = 16;  // per-requester grant counter width

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/fpmul_arb_tagpipe.sv
// fpmul_arb_tagpipe: LAT-deep valid+tag shift register that follows each
// issue through the shared FPmul, so the tail lines up with MUL_VOUT.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   vld_i, tag_i  : issue valid and requester tag (aligned with MUL_VIN)
//   tail_vld_o    : an issue is expected to return this cycle
//   tail_tag_o    : requester that owns the returning result
module fpmul_arb_tagpipe
  import fpmul_arb_pkg::*;
#(
  parameter int unsigned LAT = LAT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic vld_i,
  input  logic tag_i,
  output logic tail_vld_o,
  output logic tail_tag_o
);

  logic [LAT-1:0] vld_q;
  logic [LAT-1:0] tag_q;

  // Shift issue markers towards the tail one stage per cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q[0] <= vld_i;
      tag_q[0] <= tag_i;
      for (int i = 1; i < int'(LAT); i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign tail_vld_o = vld_q[LAT-1];
  assign tail_tag_o = tag_q[LAT-1];

endmodule

// File: rtl/fpmul_arb.sv
// fpmul_arb: round-robin arbiter sharing one pipelined FPmul between two
// requesters, routing results back by tag, with STOP/RUN/DRAIN control.
//   CLK, RST            : clock, synchronous active-high reset
//   EN                  : issue enable; low drains the pipeline to STOP
//   VINk, Ak, Bk        : requester k operand valid and operands
//   RDYk                : requester k accepted this cycle (combinational)
//   MUL_VIN/MUL_A/MUL_B : registered issue to the shared FPmul
//   MUL_VOUT/MUL_Z      : FPmul result
//   VOUTk, Zk           : registered routed results (no backpressure)
//   IDLE                : high in STOP
//   ERR                 : sticky protocol error (MUL_VOUT vs expected return)
//   GNT_CNTk            : saturating grant counters
// Optional feature macro: FPMUL_ARB_STATS_EN enables the grant counters;
// without it GNT_CNT0/GNT_CNT1 are tied to zero.
module fpmul_arb
  import fpmul_arb_pkg::*;
#(
  parameter int unsigned W   = W_DEF,
  parameter int unsigned LAT = LAT_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic                 VIN0,
  input  logic                 VIN1,
  input  logic [W-1:0]         A0,
  input  logic [W-1:0]         B0,
  input  logic [W-1:0]         A1,
  input  logic [W-1:0]         B1,
  output logic                 RDY0,
  output logic                 RDY1,
  output logic                 MUL_VIN,
  output logic [W-1:0]         MUL_A,
  output logic [W-1:0]         MUL_B,
  input  logic                 MUL_VOUT,
  input  logic [W-1:0]         MUL_Z,
  output logic                 VOUT0,
  output logic                 VOUT1,
  output logic [W-1:0]         Z0,
  output logic [W-1:0]         Z1,
  output logic                 IDLE,
  output logic                 ERR,
  output logic [GNT_CNT_W-1:0] GNT_CNT0,
  output logic [GNT_CNT_W-1:0] GNT_CNT1
);

  localparam int unsigned IF_W  = $clog2(LAT + 2);
  localparam int unsigned BLK_W = $clog2(LAT + 1);

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             gnt0, gnt1, gnt_any;
  logic [IF_W-1:0]  inflt_q, inflt_d;
  logic [BLK_W-1:0] blank_q;
  logic             mul_vin_q, mul_tag_q;
  logic [W-1:0]     mul_a_q, mul_b_q;
  logic             vout0_q, vout1_q;
  logic [W-1:0]     z0_q, z1_q;
  logic             idle_q, err_q;
  logic             tail_vld, tail_tag;
  logic             ret, err_set;

  // Next state and round-robin grant; grants only while RUN with EN high.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    case (state_q)
      ST_STOP: begin
        if (EN) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!EN) begin
          state_d = ST_DRAIN;
        end else if (!RST) begin
          if (VIN0 && VIN1) begin
            gnt0  = !ptr_q;
            gnt1  = ptr_q;
            ptr_d = !ptr_q;
          end else if (VIN0) begin
            gnt0  = 1'b1;
            ptr_d = 1'b1;
          end else if (VIN1) begin
            gnt1  = 1'b1;
            ptr_d = 1'b0;
          end
        end
      end
      ST_DRAIN: begin
        if (EN)                 state_d = ST_RUN;
        else if (inflt_q == '0) state_d = ST_STOP;
      end
      default: state_d = ST_STOP;
    endcase
  end

  assign gnt_any = gnt0 | gnt1;
  assign RDY0    = gnt0;
  assign RDY1    = gnt1;

  fpmul_arb_tagpipe #(.LAT(LAT)) u_tagpipe (
    .clk_i      (CLK),
    .rst_i      (RST),
    .vld_i      (mul_vin_q),
    .tag_i      (mul_tag_q),
    .tail_vld_o (tail_vld),
    .tail_tag_o (tail_tag)
  );

  assign ret = MUL_VOUT && tail_vld;
  // Stray MUL_VOUT is ignored while the post-reset blank window is open.
  assign err_set = (MUL_VOUT && !tail_vld && (blank_q == '0)) ||
                   (tail_vld && !MUL_VOUT);

  // In-flight count: +1 on grant, -1 when the expected return reaches the tail.
  always_comb begin
    inflt_d = inflt_q;
    case ({gnt_any, tail_vld})
      2'b10:   inflt_d = inflt_q + IF_W'(1);
      2'b01:   inflt_d = inflt_q - IF_W'(1);
      default: inflt_d = inflt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_STOP;
      ptr_q     <= 1'b0;
      inflt_q   <= '0;
      blank_q   <= BLK_W'(LAT);
      mul_vin_q <= 1'b0;
      mul_tag_q <= 1'b0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      vout0_q   <= 1'b0;
      vout1_q   <= 1'b0;
      z0_q      <= '0;
      z1_q      <= '0;
      idle_q    <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      inflt_q   <= inflt_d;
      if (blank_q != '0) blank_q <= blank_q - BLK_W'(1);
      mul_vin_q <= gnt_any;
      if (gnt_any) begin
        mul_tag_q <= gnt1;
        mul_a_q   <= gnt1 ? A1 : A0;
        mul_b_q   <= gnt1 ? B1 : B0;
      end
      vout0_q <= ret && !tail_tag;
      vout1_q <= ret && tail_tag;
      if (ret && !tail_tag) z0_q <= MUL_Z;
      if (ret && tail_tag)  z1_q <= MUL_Z;
      idle_q <= (state_d == ST_STOP);
      if (err_set) err_q <= 1'b1;
    end
  end

  assign MUL_VIN = mul_vin_q;
  assign MUL_A   = mul_a_q;
  assign MUL_B   = mul_b_q;
  assign VOUT0   = vout0_q;
  assign VOUT1   = vout1_q;
  assign Z0      = z0_q;
  assign Z1      = z1_q;
  assign IDLE    = idle_q;
  assign ERR     = err_q;

`ifdef FPMUL_ARB_STATS_EN
  logic [GNT_CNT_W-1:0] gnt_cnt0_q, gnt_cnt1_q;

  // Saturating grant counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      gnt_cnt0_q <= '0;
      gnt_cnt1_q <= '0;
    end else begin
      if (gnt0 && !(&gnt_cnt0_q)) gnt_cnt0_q <= gnt_cnt0_q + GNT_CNT_W'(1);
      if (gnt1 && !(&gnt_cnt1_q)) gnt_cnt1_q <= gnt_cnt1_q + GNT_CNT_W'(1);
    end
  end

  assign GNT_CNT0 = gnt_cnt0_q;
  assign GNT_CNT1 = gnt_cnt1_q;
`else
  assign GNT_CNT0 = '0;
  assign GNT_CNT1 = '0;
`endif

endmodule

// File: doc/fpmul_arb.md
FPMUL_ARB -- requirements
Module: fpmul_arb

Interface
REQ-001 SHALL have parameter: W, 32, operand/result width (IEEE-754 single).
REQ-002 SHALL have parameter: LAT, 4, FPmul latency MUL_VIN->MUL_VOUT in cycles (>=1).
REQ-003 SHALL have port: CLK  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port: RST  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port: EN  in  1  issue enable; low requests drain.
REQ-006 SHALL have ports: VIN0/VIN1  in  1  requester k operand valid.
REQ-007 SHALL have ports: A0,B0/A1,B1  in  W  requester k operands.
REQ-008 SHALL have ports: RDY0/RDY1  out  1  requester k accepted this cycle (combinational).
REQ-009 SHALL have ports: MUL_VIN out 1, MUL_A/MUL_B out W  registered issue to shared FPmul.
REQ-010 SHALL have ports: MUL_VOUT in 1, MUL_Z in W  FPmul result.
REQ-011 SHALL have ports: VOUT0/VOUT1 out 1, Z0/Z1 out W  routed results, registered.
REQ-012 SHALL have port: IDLE  out  1  high in STOP state.
REQ-013 SHALL have port: ERR  out  1  sticky protocol error.
REQ-014 SHALL have ports: GNT_CNT0/GNT_CNT1  out  16  grant counters (see Configuration).

Function
REQ-015 SHALL implement FSM STOP/RUN/DRAIN: STOP->RUN when EN; RUN->DRAIN when !EN; DRAIN->RUN when EN; DRAIN->STOP when !EN and in-flight count==0.
REQ-016 SHALL grant only in RUN; RDYk = grant to k; transfer occurs when VINk && RDYk.
REQ-017 SHALL arbitrate round-robin: single requester always granted; both requesting -> grant pointer side, pointer then moves to the other side; pointer unchanged with no grant.
REQ-018 SHALL register granted A/B onto MUL_A/MUL_B with MUL_VIN=1 the next cycle; MUL_VIN=0 otherwise (MUL_A/B hold).
REQ-019 SHALL track each issue with a LAT-deep valid+tag shift register aligned with MUL_VIN.
REQ-020 SHALL, when MUL_VOUT and tail valid, drive VOUTtag=1, Ztag=MUL_Z next cycle; other VOUT=0; accept->VOUTk latency = LAT+2 cycles, throughput one op/cycle.
REQ-021 SHALL keep in-flight count (0..LAT+1) = issued-not-returned; simultaneous issue and return leaves count unchanged.
REQ-022 SHALL set ERR on MUL_VOUT without tail valid or tail valid without MUL_VOUT; ERR clears only on RST.
REQ-023 SHALL NOT apply backpressure to results; requesters must sink VOUTk every cycle.
REQ-024 SHALL, on EN falling with op in pipeline, still return every in-flight result before IDLE.

Reset
REQ-025 SHALL, on RST, force STOP, pointer=0, shift register and counts cleared, all VOUT/MUL_VIN/RDY/ERR=0, Z/MUL_A/MUL_B=0, IDLE=1.
REQ-026 SHALL, on RST mid-operation, discard in-flight ops; late MUL_VOUT in the following LAT cycles SHALL NOT set ERR (masked by post-reset blank counter).

Configuration
REQ-027 SHALL, with FPMUL_ARB_STATS_EN defined, count grants per requester in GNT_CNTk, saturating at 16'hFFFF, cleared by RST.
REQ-028 SHALL, without FPMUL_ARB_STATS_EN, tie GNT_CNT0/GNT_CNT1 to 0 with no counter logic.

Structure
REQ-029 SHALL place W default, LAT default, FSM state encoding and counter width in package fpmul_arb_pkg.
REQ-030 SHALL implement the tag/valid pipeline as sub-module fpmul_arb_tagpipe (parameter LAT).

Verification
REQ-031 SHALL test single requester: VIN0 with A0=3F800000,B0=40000000 at cycle t -> RDY0 at t, VOUT0 at t+LAT+2, Z0=40000000 (model FPmul).
REQ-032 SHALL test contention: VIN0=VIN1=1 for 4 cycles after reset -> grants 0,1,0,1; results return in that order on VOUT0/VOUT1.
REQ-033 SHALL test drain: EN=0 with 3 ops in flight -> RDY=0 immediately, 3 VOUTs delivered, IDLE=1 exactly one cycle after last return.
REQ-034 SHALL test protocol error: inject MUL_VOUT=1 with empty pipeline -> ERR=1 next cycle, stays until RST.
REQ-035 SHALL test reset mid-stream: RST with 2 ops in flight -> no VOUT, ERR=0, IDLE=1; with FPMUL_ARB_STATS_EN, GNT_CNT saturates at FFFF after 65540 grants.
